// File: rtl/nios2_command_mailbox_if.sv
// Avalon-MM command port plus the Nios-side valid/ready drain stream.
// The slave modport is the mailbox; the master modport is the HPS/consumer side.
interface nios2_command_mailbox_if #(
  parameter int DATA_WIDTH = 32
);
  logic [1:0]            address;
  logic                  chipselect;
  logic                  write_n;
  logic [31:0]           writedata;
  logic [31:0]           readdata;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  irq;

  modport slave (
    input  address, chipselect, write_n, writedata, out_ready,
    output readdata, out_data, out_valid, irq
  );

  modport master (
    output address, chipselect, write_n, writedata, out_ready,
    input  readdata, out_data, out_valid, irq
  );
endinterface

// File: rtl/nios2_command_mailbox.sv
// HPS-to-Nios command FIFO with STATUS/CONTROL/LAST registers, sticky overflow,
// flush and a level interrupt. First-word fall-through on the drain side.
module nios2_command_mailbox #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  nios2_command_mailbox_if.slave    bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;
  logic                  r_irq_en;
  logic [DATA_WIDTH-1:0] r_last;

  logic w_wr, w_push_req, w_ctrl_wr, w_flush_wr, w_ovf_clr;
  logic w_empty, w_full, w_pop, w_push_acc, w_drop;

  assign w_wr       = bus.chipselect & ~bus.write_n;
  assign w_push_req = w_wr & (bus.address == 2'd0);
  assign w_ctrl_wr  = w_wr & (bus.address == 2'd2);
  assign w_flush_wr = w_ctrl_wr & bus.writedata[1];
  assign w_ovf_clr  = w_wr & (bus.address == 2'd1) & bus.writedata[18];
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_pop      = ~w_empty & bus.out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push_acc = w_push_req & (~w_full | w_pop) & ~w_flush_wr;
  assign w_drop     = w_push_req & ~w_push_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_irq_en   <= 1'b0;
      r_last     <= '0;
    end else begin
      if (w_flush_wr) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)      r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push_acc, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
      if (w_push_acc) r_last <= bus.writedata[DATA_WIDTH-1:0];
      if (w_drop)
        r_overflow <= 1'b1;
      else if (w_ovf_clr)
        r_overflow <= 1'b0;
      if (w_ctrl_wr) r_irq_en <= bus.writedata[0];
    end
  end

  // Storage is deliberately unreset; count/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push_acc & ~reset) r_mem[r_wr_ptr] <= bus.writedata[DATA_WIDTH-1:0];
  end

  assign bus.out_valid = ~w_empty;
  assign bus.out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.irq       = r_irq_en & (~w_empty | r_overflow);

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd1: begin
        bus.readdata[CNT_W-1:0] = r_count;
        bus.readdata[16]        = w_empty;
        bus.readdata[17]        = w_full;
        bus.readdata[18]        = r_overflow;
      end
      2'd2:    bus.readdata[0] = r_irq_en;
      2'd3:    bus.readdata[DATA_WIDTH-1:0] = r_last;
      default: bus.readdata = '0;
    endcase
  end
endmodule

// File: tb/tb_nios2_command_mailbox.sv
// Two mailbox instances (32b x 16 and 8b x 4) share one bus stimulus; each is
// checked every cycle against a queue-based model plus literal expectations.
module tb_nios2_command_mailbox;
  logic        clk;
  logic        rst, cs, wn, rdy;
  logic [1:0]  addr;
  logic [31:0] wd;

  nios2_command_mailbox_if #(.DATA_WIDTH(32)) ifa ();
  nios2_command_mailbox_if #(.DATA_WIDTH(8))  ifb ();

  assign ifa.address = addr;  assign ifb.address = addr;
  assign ifa.chipselect = cs; assign ifb.chipselect = cs;
  assign ifa.write_n = wn;    assign ifb.write_n = wn;
  assign ifa.writedata = wd;  assign ifb.writedata = wd;
  assign ifa.out_ready = rdy; assign ifb.out_ready = rdy;

  nios2_command_mailbox #(.DATA_WIDTH(32), .DEPTH(16)) dut_a (
    .clk(clk), .reset(rst), .bus(ifa.slave));
  nios2_command_mailbox #(.DATA_WIDTH(8), .DEPTH(4)) dut_b (
    .clk(clk), .reset(rst), .bus(ifb.slave));

  logic [31:0] d_rd [2];
  logic [31:0] d_od [2];
  logic        d_ov [2];
  logic        d_irq [2];
  assign d_rd[0] = ifa.readdata;  assign d_rd[1] = ifb.readdata;
  assign d_od[0] = ifa.out_data;  assign d_od[1] = {24'b0, ifb.out_data};
  assign d_ov[0] = ifa.out_valid; assign d_ov[1] = ifb.out_valid;
  assign d_irq[0] = ifa.irq;      assign d_irq[1] = ifb.irq;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  // Behavioural model: one command queue per instance.
  int          DW [2] = '{32, 8};
  int          DP [2] = '{16, 4};
  logic [31:0] mq [2][$];
  bit          m_ovf [2];
  bit          m_en [2];
  logic [31:0] m_last [2];

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input int k, input logic [1:0] a);
    logic [31:0] r;
    int n;
    r = '0;
    n = mq[k].size();
    case (a)
      2'd1: begin r = 32'(n); r[16] = (n == 0); r[17] = (n == DP[k]); r[18] = m_ovf[k]; end
      2'd2: r[0] = m_en[k];
      2'd3: r = m_last[k];
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit wr, popped;
      int n;
      logic [31:0] mask;
      if (rst) begin
        mq[k].delete(); m_ovf[k] = 0; m_en[k] = 0; m_last[k] = '0;
      end else begin
        wr = cs && !wn;
        n = mq[k].size();
        mask = (DW[k] == 32) ? 32'hFFFF_FFFF : ((32'h1 << DW[k]) - 1);
        if (wr && addr == 2) m_en[k] = wd[0];
        if (wr && addr == 2 && wd[1]) begin
          mq[k].delete();
        end else begin
          popped = (n > 0) && rdy;
          if (popped) void'(mq[k].pop_front());
          if (wr && addr == 0) begin
            if (n < DP[k] || popped) begin
              mq[k].push_back(wd & mask);
              m_last[k] = wd & mask;
            end else m_ovf[k] = 1;
          end
        end
        if (wr && addr == 1 && wd[18]) m_ovf[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        int n;
        n = mq[k].size();
        chk("out_valid", k, 32'(d_ov[k]), 32'(n > 0));
        chk("out_data", k, d_od[k], (n > 0) ? mq[k][0] : 32'h0);
        chk("irq", k, 32'(d_irq[k]), 32'(m_en[k] && (n > 0 || m_ovf[k])));
        chk("readdata", k, d_rd[k], exp_rd(k, addr));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cs = 1; wn = 0; addr = a; wd = d;
    step();
    cs = 0; wn = 1;
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] ea, input logic [31:0] eb);
    addr = a; #1;
    chk(nm, 0, d_rd[0], ea);
    chk(nm, 1, d_rd[1], eb);
  endtask

  initial begin
    rst = 1; cs = 0; wn = 1; addr = 0; wd = 0; rdy = 0;
    step(); started = 1;
    step(); rst = 0;

    rd_chk("rst_data", 0, 0, 0);
    rd_chk("rst_status", 1, 32'h0001_0000, 32'h0001_0000);
    rd_chk("rst_ctrl", 2, 0, 0);
    rd_chk("rst_last", 3, 0, 0);
    chk("rst_valid", 0, 32'(ifa.out_valid), 0);
    chk("rst_irq", 0, 32'(ifa.irq), 0);

    wr(0, 32'hA5A5_0001);
    chk("push1_valid", 0, 32'(ifa.out_valid), 1);
    chk("push1_data", 0, ifa.out_data, 32'hA5A5_0001);
    chk("push1_data", 1, 32'(ifb.out_data), 32'h01);
    rd_chk("push1_status", 1, 32'h1, 32'h1);
    rd_chk("push1_last", 3, 32'hA5A5_0001, 32'h01);
    rdy = 1; step(); rdy = 0;
    chk("pop1_valid", 0, 32'(ifa.out_valid), 0);
    rd_chk("pop1_status", 1, 32'h0001_0000, 32'h0001_0000);

    for (int i = 1; i <= 17; i++) wr(0, 32'(i));
    rd_chk("full_status", 1, 32'h0006_0010, 32'h0006_0004);
    rd_chk("full_last", 3, 32'd16, 32'd4);
    chk("model_cnt", 0, 32'(mq[0].size()), 16);
    rdy = 1;
    for (int i = 1; i <= 16; i++) begin
      chk("drain_seq", 0, ifa.out_data, 32'(i));
      step();
    end
    rdy = 0;
    wr(1, 32'h0004_0000);
    rd_chk("w1c_status", 1, 32'h0001_0000, 32'h0001_0000);

    for (int i = 0; i < 16; i++) wr(0, 32'h100 + 32'(i));
    rdy = 1;
    wr(0, 32'h99);
    rd_chk("fullpop_status", 1, 32'h0002_0010, 32'h0006_0004);
    repeat (15) step();
    rdy = 0;
    chk("wrap_head", 0, ifa.out_data, 32'h99);
    rd_chk("wrap_status", 1, 32'h1, 32'h0005_0000);
    wr(1, 32'h0004_0000);
    rdy = 1; step(); rdy = 0;

    wr(2, 32'h1);
    chk("irq_empty", 0, 32'(ifa.irq), 0);
    wr(0, 32'h5);
    chk("irq_set", 0, 32'(ifa.irq), 1);
    chk("irq_set", 1, 32'(ifb.irq), 1);
    wr(2, 32'h3);
    chk("flush_valid", 0, 32'(ifa.out_valid), 0);
    chk("flush_irq", 0, 32'(ifa.irq), 0);
    rd_chk("flush_status", 1, 32'h0001_0000, 32'h0001_0000);
    rd_chk("flush_ctrl", 2, 32'h1, 32'h1);
    rd_chk("flush_last", 3, 32'h5, 32'h5);

    wr(0, 32'h1234_56AB);
    chk("narrow_data", 0, ifa.out_data, 32'h1234_56AB);
    chk("narrow_data", 1, 32'(ifb.out_data), 32'hAB);
    rd_chk("narrow_last", 3, 32'h1234_56AB, 32'hAB);
    wr(0, 32'h2); wr(0, 32'h3);
    chk("model_cnt", 1, 32'(mq[1].size()), 3);
    rst = 1; cs = 1; wn = 0; addr = 0; wd = 32'h77;
    step();
    rst = 0; cs = 0; wn = 1;
    chk("mrst_valid", 1, 32'(ifb.out_valid), 0);
    chk("mrst_irq", 1, 32'(ifb.irq), 0);
    rd_chk("mrst_status", 1, 32'h0001_0000, 32'h0001_0000);
    rd_chk("mrst_last", 3, 0, 0);
    rd_chk("mrst_ctrl", 2, 0, 0);

    for (int c = 0; c < 3000; c++) begin
      int r;
      rst = ($urandom % 400) == 0;
      rdy = $urandom % 2;
      cs = ($urandom % 4) != 0;
      wn = ($urandom % 3) == 0;
      r = $urandom % 10;
      addr = (r < 5) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      wd = $urandom;
      if (addr == 2 && ($urandom % 6) != 0) wd[1] = 1'b0;
      step();
    end
    rst = 0; cs = 0; wn = 1; rdy = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
